// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - state encoding, grant codes and watchdog sizing for mem_arbiter
// Purpose: shared types imported by mem_arbiter and mem_arb_watchdog.
// Ports: none (package).
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  localparam logic ARB_GNT_I = 1'b0;
  localparam logic ARB_GNT_D = 1'b1;

  // Watchdog counter width; a disabled watchdog still needs a legal 1-bit port.
  function automatic int wd_count_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - cycle counter that flags a memory access never acknowledged
// Purpose: counts enabled cycles since the last clear; expired marks the TIMEOUT-th one.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   clear         restart the count (held while the arbiter is idle)
//   enable        count this cycle (busy and no mem_ack)
//   count         current count, cycles already elapsed in this access
//   expired       this cycle is the TIMEOUT-th without an ack
// TIMEOUT = 0 ties count and expired to 0.
module mem_arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64,
  localparam int CW = wd_count_width(TIMEOUT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          expired
);

  if (TIMEOUT > 0) begin : g_wd
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
      if (reset || clear) begin
        count <= '0;
      end else if (enable) begin
        count <= count + 1'b1;
      end
    end

    // count holds the cycles already spent, so the current cycle is number count+1.
    assign expired = enable && (count == LAST);
  end else begin : g_no_wd
    logic unused_wd_inputs;
    assign unused_wd_inputs = ^{clk, reset, clear, enable};
    assign count   = '0;
    assign expired = 1'b0;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter sharing one memory port between fetch and load/store
// Purpose: grants IF (i_*) or MEM (d_*) requests onto mem_*, returns the response, aborts
//          accesses that exceed TIMEOUT cycles without mem_ack. All outputs are registered.
// Ports:
//   clk, reset                                  clock, synchronous active-high reset
//   i_req, i_addr / i_ready, i_rvalid, i_rdata, i_err                       fetch side
//   d_req, d_we, d_addr, d_wdata, d_wstrb / d_ready, d_rvalid, d_rdata, d_err   data side
//   mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb / mem_ack, mem_rdata        memory side
// Option: MEM_ARB_RR_EN selects round-robin for simultaneous requests; default is d over i.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      i_ready,
  output logic                      i_rvalid,
  output logic [DATA_WIDTH-1:0]     i_rdata,
  output logic                      i_err,
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_wstrb,
  output logic                      d_ready,
  output logic                      d_rvalid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  output logic                      d_err,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int CW = wd_count_width(TIMEOUT);

  arb_state_t state_q, state_d;
  logic       pick;
  logic       busy;
  logic       wd_expired;
  logic [CW-1:0] wd_count_unused;

  logic                    i_ready_n, i_rvalid_n, i_err_n;
  logic                    d_ready_n, d_rvalid_n, d_err_n;
  logic [DATA_WIDTH-1:0]   i_rdata_n, d_rdata_n;
  logic                    mem_req_n, mem_we_n;
  logic [ADDR_WIDTH-1:0]   mem_addr_n;
  logic [DATA_WIDTH-1:0]   mem_wdata_n;
  logic [DATA_WIDTH/8-1:0] mem_wstrb_n;

  assign busy = (state_q != ARB_IDLE);

`ifdef MEM_ARB_RR_EN
  logic last_grant_q;

  // Contested cycles go to the side not granted last; a lone request simply wins.
  always_comb begin
    if (i_req && d_req) begin
      pick = (last_grant_q == ARB_GNT_I) ? ARB_GNT_D : ARB_GNT_I;
    end else begin
      pick = d_req ? ARB_GNT_D : ARB_GNT_I;
    end
  end

  // Only contested grants move the pointer, so uncontested traffic does not bias it.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= ARB_GNT_I;
    end else if (!busy && i_req && d_req) begin
      last_grant_q <= pick;
    end
  end
`else
  assign pick = d_req ? ARB_GNT_D : ARB_GNT_I;
`endif

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy && !mem_ack),
    .count   (wd_count_unused),
    .expired (wd_expired)
  );

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      i_ready   <= 1'b0;
      i_rvalid  <= 1'b0;
      i_rdata   <= '0;
      i_err     <= 1'b0;
      d_ready   <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      state_q   <= state_d;
      i_ready   <= i_ready_n;
      i_rvalid  <= i_rvalid_n;
      i_rdata   <= i_rdata_n;
      i_err     <= i_err_n;
      d_ready   <= d_ready_n;
      d_rvalid  <= d_rvalid_n;
      d_rdata   <= d_rdata_n;
      d_err     <= d_err_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_wstrb <= mem_wstrb_n;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          state_d = (pick == ARB_GNT_D) ? ARB_BUSY_D : ARB_BUSY_I;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        // An ack in the expiry cycle is still a normal completion.
        if (mem_ack || wd_expired) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs; mem_* hold unless a new grant is made.
  always_comb begin
    i_ready_n   = 1'b0;
    i_rvalid_n  = 1'b0;
    i_err_n     = 1'b0;
    d_ready_n   = 1'b0;
    d_rvalid_n  = 1'b0;
    d_err_n     = 1'b0;
    i_rdata_n   = i_rdata;
    d_rdata_n   = d_rdata;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_wstrb_n = mem_wstrb;
    case (state_q)
      ARB_IDLE: begin
        if (i_req || d_req) begin
          mem_req_n = 1'b1;
          if (pick == ARB_GNT_D) begin
            d_ready_n   = 1'b1;
            mem_we_n    = d_we;
            mem_addr_n  = d_addr;
            mem_wdata_n = d_wdata;
            mem_wstrb_n = d_wstrb;
          end else begin
            i_ready_n   = 1'b1;
            mem_we_n    = 1'b0;
            mem_addr_n  = i_addr;
            mem_wdata_n = '0;
            mem_wstrb_n = '0;
          end
        end
      end
      ARB_BUSY_I: begin
        if (mem_ack) begin
          mem_req_n  = 1'b0;
          i_rvalid_n = 1'b1;
          i_rdata_n  = mem_rdata;
        end else if (wd_expired) begin
          mem_req_n  = 1'b0;
          i_rvalid_n = 1'b1;
          i_err_n    = 1'b1;
          i_rdata_n  = '0;
        end
      end
      ARB_BUSY_D: begin
        if (mem_ack) begin
          mem_req_n  = 1'b0;
          d_rvalid_n = 1'b1;
          d_rdata_n  = mem_we ? '0 : mem_rdata;
        end else if (wd_expired) begin
          mem_req_n  = 1'b0;
          d_rvalid_n = 1'b1;
          d_err_n    = 1'b1;
          d_rdata_n  = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a transaction model
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_ready, i_rvalid, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_we, d_ready, d_rvalid, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [SW-1:0] d_wstrb;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [SW-1:0] mem_wstrb;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction model: one outstanding access, its age in mem_req cycles and planned ack cycle.
  bit            os, os_d, rr_last_d, stray_en, granted, granted_d;
  int            age, ack_at, plan_ack;
  logic          e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [SW-1:0] e_wstrb;

  task automatic cycle();
    bit            r_s, ir_s, dr_s, ack_s, dwe_s, w;
    logic [AW-1:0] ia_s, da_s;
    logic [DW-1:0] wd_s, rd_s, x_rd;
    logic [SW-1:0] ws_s;
    bit            x_ir, x_dr, x_iv, x_dv, x_err;
    r_s = reset; ir_s = i_req; dr_s = d_req; ack_s = mem_ack; dwe_s = d_we;
    ia_s = i_addr; da_s = d_addr; wd_s = d_wdata; rd_s = mem_rdata; ws_s = d_wstrb;
    x_ir = 0; x_dr = 0; x_iv = 0; x_dv = 0; x_err = 0; x_rd = '0;
    granted = 0;
    @(posedge clk);
    @(negedge clk);
    if (r_s) begin
      os = 0;
      rr_last_d = 0;
    end else if (os) begin
      if (ack_s || age == TO) begin
        x_err = !ack_s;
        x_rd  = (!ack_s || (os_d && e_we)) ? '0 : rd_s;
        if (os_d) x_dv = 1; else x_iv = 1;
        os = 0;
      end else begin
        age++;
      end
    end else if (ir_s || dr_s) begin
`ifdef MEM_ARB_RR_EN
      if (ir_s && dr_s) begin
        w = !rr_last_d;
        rr_last_d = w;
      end else begin
        w = dr_s;
      end
`else
      w = dr_s;
`endif
      os = 1; os_d = w; age = 1; granted = 1; granted_d = w;
      e_we    = w ? dwe_s : 1'b0;
      e_addr  = w ? da_s : ia_s;
      e_wdata = wd_s;
      e_wstrb = w ? ws_s : '0;
      if (w) x_dr = 1; else x_ir = 1;
      if (plan_ack >= 0) ack_at = plan_ack;
      else ack_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
      if (w) d_req = 0; else i_req = 0;
    end
    check_eq("i_ready", 64'(i_ready), 64'(x_ir));
    check_eq("d_ready", 64'(d_ready), 64'(x_dr));
    check_eq("i_rvalid", 64'(i_rvalid), 64'(x_iv));
    check_eq("d_rvalid", 64'(d_rvalid), 64'(x_dv));
    check_eq("mem_req", 64'(mem_req), 64'(os));
    if (x_iv) begin
      check_eq("i_rdata", 64'(i_rdata), 64'(x_rd));
      check_eq("i_err", 64'(i_err), 64'(x_err));
    end
    if (x_dv) begin
      check_eq("d_rdata", 64'(d_rdata), 64'(x_rd));
      check_eq("d_err", 64'(d_err), 64'(x_err));
    end
    if (os) begin
      check_eq("mem_we", 64'(mem_we), 64'(e_we));
      check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
      check_eq("mem_wstrb", 64'(mem_wstrb), 64'(e_wstrb));
      if (e_we) check_eq("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    end
    mem_ack   = (os && age == ack_at) || (!os && stray_en && $urandom_range(0, 5) == 0);
    mem_rdata = $urandom;
  endtask

  task automatic gen();
    if (!i_req && $urandom_range(0, 2) == 0) begin
      i_req = 1; i_addr = $urandom;
    end
    if (!d_req && $urandom_range(0, 2) == 0) begin
      d_req = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
      d_wdata = $urandom; d_wstrb = 4'($urandom);
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    stray_en = 0;
    while ((i_req || d_req || os) && n < 40) begin
      cycle();
      n++;
    end
    check_eq("settle_idle", 64'(i_req || d_req || os), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_i_ready"}, 64'(i_ready), 0);
    check_eq({tag, "_i_rvalid"}, 64'(i_rvalid), 0);
    check_eq({tag, "_i_rdata"}, 64'(i_rdata), 0);
    check_eq({tag, "_i_err"}, 64'(i_err), 0);
    check_eq({tag, "_d_ready"}, 64'(d_ready), 0);
    check_eq({tag, "_d_rvalid"}, 64'(d_rvalid), 0);
    check_eq({tag, "_d_rdata"}, 64'(d_rdata), 0);
    check_eq({tag, "_d_err"}, 64'(d_err), 0);
    check_eq({tag, "_mem_req"}, 64'(mem_req), 0);
    check_eq({tag, "_mem_we"}, 64'(mem_we), 0);
    check_eq({tag, "_mem_addr"}, 64'(mem_addr), 0);
    check_eq({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
    check_eq({tag, "_mem_wstrb"}, 64'(mem_wstrb), 0);
  endtask

  initial begin
    int n, cnt;
    logic [3:0] seq;
    reset = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_wstrb = '0; mem_ack = 0; mem_rdata = '0;
    os = 0; rr_last_d = 0; stray_en = 0; plan_ack = -1; age = 0; ack_at = 0;
    cycle();
    cycle();
    check_all_zero("rst");
    reset = 0;
    cycle();

    // Lone fetch, ack in the 4th mem_req cycle.
    plan_ack = 4; i_req = 1; i_addr = 32'h100;
    cycle();
    check_eq("fetch_granted", 64'(granted), 1);
    n = 0;
    do begin cycle(); n++; end while (!i_rvalid && n < 20);
    check_eq("fetch_lat", 64'(n), 64'd4);

    // Store with ack in the first cycle.
    plan_ack = 1; d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'b0011;
    cycle();
    cycle();
    check_eq("store_rvalid", 64'(d_rvalid), 1);
    settle();

    // Both sides held for four grants.
    plan_ack = 1; seq = '0; cnt = 0; n = 0;
    i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
    while (cnt < 4 && n < 40) begin
      cycle();
      n++;
      if (granted) begin
        seq = {seq[2:0], granted_d};
        cnt++;
      end
      if (cnt < 4) begin
        i_req = 1;
        d_req = 1;
      end
    end
    check_eq("both_grants", 64'(cnt), 64'd4);
`ifdef MEM_ARB_RR_EN
    check_eq("rr_alternate", 64'(seq ^ {seq[2:0], ~seq[0]}), 64'hF);
`else
    check_eq("prio_seq", 64'(seq), 64'hF);
`endif
    settle();

    // Watchdog abort, then ack landing in the last allowed cycle.
    plan_ack = 0; d_req = 1; d_we = 0; d_addr = 32'h300;
    cycle();
    n = 1;
    cnt = 0;
    while (!d_rvalid && cnt < 20) begin
      cycle();
      cnt++;
      if (mem_req) n++;
    end
    check_eq("to_req_cycles", 64'(n), 64'd8);
    check_eq("to_err", 64'(d_err), 1);
    plan_ack = 8; d_req = 1; d_addr = 32'h304;
    cnt = 0;
    do begin cycle(); cnt++; end while (!d_rvalid && cnt < 20);
    check_eq("ack8_rvalid", 64'(d_rvalid), 1);
    check_eq("ack8_err", 64'(d_err), 0);
    settle();

    // Stray ack while idle.
    mem_ack = 1;
    cycle();
    check_eq("stray_rvalid", 64'(i_rvalid || d_rvalid), 0);
    plan_ack = 1; i_req = 1; i_addr = 32'h500;
    cycle();
    check_eq("after_stray_ready", 64'(i_ready), 1);
    settle();

    // Reset two cycles into a fetch, then a fresh fetch.
    plan_ack = 0; i_req = 1; i_addr = 32'h600;
    cycle();
    cycle();
    reset = 1;
    cycle();
    check_all_zero("midrst");
    reset = 0;
    repeat (3) cycle();
    plan_ack = 2; i_req = 1; i_addr = 32'h700;
    cnt = 0;
    do begin cycle(); cnt++; end while (!i_rvalid && cnt < 20);
    check_eq("fresh_rvalid", 64'(i_rvalid), 1);
    check_eq("fresh_err", 64'(i_err), 0);
    settle();

    // Random traffic with random ack timing and stray acks.
    plan_ack = -1;
    repeat (800) begin
      stray_en = 1;
      cycle();
      gen();
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

endmodule
